// File: rtl/abr_prim_onehot_pkg.sv
// Shared types for the one-hot select generator.
//   sel_gen_state_e : sparse FSM encoding, pairwise Hamming distance >= 3
//   gap_cnt_width() : width of the break-before-make gap counter
package abr_prim_onehot_pkg;

   localparam int unsigned StateWidth = 5;

   // Pairwise distances: I-A 3, I-G 3, I-E 4, A-G 4, A-E 3, G-E 3.
   localparam logic [StateWidth-1:0] StIdle   = 5'b00000;
   localparam logic [StateWidth-1:0] StActive = 5'b00111;
   localparam logic [StateWidth-1:0] StGap    = 5'b11001;
   localparam logic [StateWidth-1:0] StError  = 5'b11110;

   typedef enum logic [StateWidth-1:0] {
      SelIdle   = StIdle,
      SelActive = StActive,
      SelGap    = StGap,
      SelError  = StError
   } sel_gen_state_e;

   // $clog2(gap+1), floored at 1 so the counter always has a legal width.
   function automatic int unsigned gap_cnt_width(input int unsigned gap);
      int unsigned w;
      if (gap == 0) begin
         w = 1;
      end else begin
         w = $unsigned($clog2(gap + 1));
      end
      return w;
   endfunction

endpackage

// File: rtl/abr_prim_bin2onehot.sv
// Combinational binary-to-one-hot decoder with enable.
//   addr_i : binary index
//   en_i   : 0 forces an all-zero output
//   oh_o   : one-hot result; indices >= OneHotWidth decode to all-zero
module abr_prim_bin2onehot #(
   parameter int unsigned AddrWidth   = 5,
   parameter int unsigned OneHotWidth = 2**AddrWidth
) (
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic                   en_i,
   output logic [OneHotWidth-1:0] oh_o
);

   for (genvar i = 0; i < OneHotWidth; i++) begin : g_dec
      assign oh_o[i] = en_i && (addr_i == AddrWidth'(i));
   end

endmodule

// File: rtl/abr_prim_onehot_sel_gen.sv
// Sequential one-hot select generator with break-before-make gaps and a
// self-check of its own registered state.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_valid_i/ready_o   : request handshake
//   req_addr_i, req_en_i  : requested index / select (1) or deselect-all (0)
//   oh_o, addr_o, en_o    : registered one-hot select triple
//   busy_o                : high while inserting a gap
//   err_o                 : sticky error, cleared only by reset
module abr_prim_onehot_sel_gen
   import abr_prim_onehot_pkg::*;
#(
   parameter int unsigned AddrWidth   = 5,
   parameter int unsigned OneHotWidth = 2**AddrWidth,
   parameter int unsigned GapCycles   = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic                   req_en_i,
   output logic [OneHotWidth-1:0] oh_o,
   output logic [AddrWidth-1:0]   addr_o,
   output logic                   en_o,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int unsigned CntW = gap_cnt_width(GapCycles);
   localparam logic [CntW-1:0] CntLoad = (GapCycles > 0) ? CntW'(GapCycles - 1) : '0;

   sel_gen_state_e         state_q, state_d;
   logic [OneHotWidth-1:0] oh_q, oh_d, oh_chk;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [AddrWidth-1:0]   pend_q, pend_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   en_q, en_d;
   logic                   busy_q, busy_d;
   logic                   ready_q, ready_d;
   logic                   err_q, err_d;

   logic accept;
   logic illegal_addr;
   logic chk_fail;

   assign accept       = req_valid_i && ready_q;
   assign illegal_addr = (32'(req_addr_i) >= OneHotWidth);

   // Next-state one-hot comes from the same decoder as the check path.
   abr_prim_bin2onehot #(
      .AddrWidth   (AddrWidth),
      .OneHotWidth (OneHotWidth)
   ) u_dec_next (
      .addr_i (addr_d),
      .en_i   (en_d),
      .oh_o   (oh_d)
   );

   // Independent re-decode of the registered address/enable.
   abr_prim_bin2onehot #(
      .AddrWidth   (AddrWidth),
      .OneHotWidth (OneHotWidth)
   ) u_dec_chk (
      .addr_i (addr_q),
      .en_i   (en_q),
      .oh_o   (oh_chk)
   );

   // Registered state must be self-consistent; IDLE and GAP must be all-zero.
   always_comb begin
      chk_fail = (oh_q != oh_chk) || (en_q != (|oh_q));
      if (((state_q == SelIdle) || (state_q == SelGap)) && (|oh_q)) begin
         chk_fail = 1'b1;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      err_d   = err_q;

      unique case (state_q)
         SelIdle: begin
            if (chk_fail) begin
               state_d = SelError;
            end else if (accept && req_en_i) begin
               if (illegal_addr) begin
                  state_d = SelError;
               end else begin
                  state_d = SelActive;
                  addr_d  = req_addr_i;
                  en_d    = 1'b1;
               end
            end
         end
         SelActive: begin
            if (chk_fail) begin
               state_d = SelError;
            end else if (accept) begin
               if (!req_en_i) begin
                  state_d = SelIdle;
                  en_d    = 1'b0;
               end else if (illegal_addr) begin
                  state_d = SelError;
               end else if (req_addr_i != addr_q) begin
                  if (GapCycles == 0) begin
                     addr_d = req_addr_i;
                  end else begin
                     state_d = SelGap;
                     pend_d  = req_addr_i;
                     cnt_d   = CntLoad;
                     en_d    = 1'b0;
                  end
               end
            end
         end
         SelGap: begin
            if (chk_fail) begin
               state_d = SelError;
            end else if (cnt_q == '0) begin
               state_d = SelActive;
               addr_d  = pend_q;
               en_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         SelError: begin
            state_d = SelError;
         end
         default: begin
            state_d = SelError;
         end
      endcase

      // Every path into ERROR drops the select and latches the error.
      if (state_d == SelError) begin
         en_d  = 1'b0;
         err_d = 1'b1;
      end

      busy_d  = (state_d == SelGap);
      ready_d = (state_d == SelIdle) || (state_d == SelActive);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SelIdle;
         oh_q    <= '0;
         addr_q  <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         oh_q    <= oh_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o = ready_q;
   assign oh_o        = oh_q;
   assign addr_o      = addr_q;
   assign en_o        = en_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_abr_prim_onehot_sel_gen.sv
// Directed bench for abr_prim_onehot_sel_gen: a 20-line instance with a
// 2-cycle gap and a 32-line instance with direct switching.
module tb_abr_prim_onehot_sel_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Instance A: AddrWidth 5, OneHotWidth 20, GapCycles 2
   logic        a_valid, a_ready, a_en_i, a_en_o, a_busy, a_err;
   logic [4:0]  a_addr_i, a_addr_o;
   logic [19:0] a_oh;

   // Instance B: AddrWidth 5, OneHotWidth 32, GapCycles 0
   logic        b_valid, b_ready, b_en_i, b_en_o, b_busy, b_err;
   logic [4:0]  b_addr_i, b_addr_o;
   logic [31:0] b_oh;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   abr_prim_onehot_sel_gen #(
      .AddrWidth   (5),
      .OneHotWidth (20),
      .GapCycles   (2)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (a_valid),
      .req_ready_o (a_ready),
      .req_addr_i  (a_addr_i),
      .req_en_i    (a_en_i),
      .oh_o        (a_oh),
      .addr_o      (a_addr_o),
      .en_o        (a_en_o),
      .busy_o      (a_busy),
      .err_o       (a_err)
   );

   abr_prim_onehot_sel_gen #(
      .AddrWidth   (5),
      .OneHotWidth (32),
      .GapCycles   (0)
   ) u_dut_g0 (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (b_valid),
      .req_ready_o (b_ready),
      .req_addr_i  (b_addr_i),
      .req_en_i    (b_en_i),
      .oh_o        (b_oh),
      .addr_o      (b_addr_o),
      .en_o        (b_en_o),
      .busy_o      (b_busy),
      .err_o       (b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_reset(input string tag);
      chk({tag, ".oh"},    32'(a_oh),     32'h0);
      chk({tag, ".addr"},  32'(a_addr_o), 32'h0);
      chk({tag, ".en"},    32'(a_en_o),   32'h0);
      chk({tag, ".busy"},  32'(a_busy),   32'h0);
      chk({tag, ".err"},   32'(a_err),    32'h0);
      chk({tag, ".ready"}, 32'(a_ready),  32'h1);
   endtask

   initial begin
      a_valid = 1'b0; a_en_i = 1'b0; a_addr_i = '0;
      b_valid = 1'b0; b_en_i = 1'b0; b_addr_i = '0;

      // Reset values while reset is held
      #12;
      chk_a_reset("rst");
      chk("rst.b_oh", b_oh, 32'h0);
      rst = 1'b0;

      // Select 5 from IDLE: one-cycle latency
      a_valid = 1'b1; a_en_i = 1'b1; a_addr_i = 5'd5;
      tick();
      chk("sel5.oh",    32'(a_oh),     32'h0000_0020);
      chk("sel5.addr",  32'(a_addr_o), 32'd5);
      chk("sel5.en",    32'(a_en_o),   32'h1);
      chk("sel5.err",   32'(a_err),    32'h0);
      chk("sel5.ready", 32'(a_ready),  32'h1);

      // Switch 5 -> 9: two gap cycles then the new select
      a_addr_i = 5'd9;
      tick();
      a_valid = 1'b0;
      chk("gap1.oh",    32'(a_oh),    32'h0);
      chk("gap1.en",    32'(a_en_o),  32'h0);
      chk("gap1.busy",  32'(a_busy),  32'h1);
      chk("gap1.ready", 32'(a_ready), 32'h0);
      tick();
      chk("gap2.oh",    32'(a_oh),    32'h0);
      chk("gap2.busy",  32'(a_busy),  32'h1);
      chk("gap2.ready", 32'(a_ready), 32'h0);
      tick();
      chk("sel9.oh",    32'(a_oh),     32'h0000_0200);
      chk("sel9.addr",  32'(a_addr_o), 32'd9);
      chk("sel9.busy",  32'(a_busy),   32'h0);
      chk("sel9.ready", 32'(a_ready),  32'h1);

      // Reselect the same address: no gap, no glitch
      a_valid = 1'b1; a_en_i = 1'b1; a_addr_i = 5'd9;
      tick();
      chk("same.oh",   32'(a_oh),   32'h0000_0200);
      chk("same.busy", 32'(a_busy), 32'h0);

      // Deselect: back to IDLE, address holds
      a_en_i = 1'b0;
      tick();
      a_valid = 1'b0;
      chk("desel.oh",    32'(a_oh),     32'h0);
      chk("desel.en",    32'(a_en_o),   32'h0);
      chk("desel.addr",  32'(a_addr_o), 32'd9);
      chk("desel.ready", 32'(a_ready),  32'h1);

      // Random legal traffic: structural invariants every cycle
      for (int i = 0; i < 300; i++) begin
         a_valid  = 1'($urandom_range(0, 1));
         a_en_i   = 1'($urandom_range(0, 3) != 0);
         a_addr_i = 5'($urandom_range(0, 19));
         tick();
         chk("rnd.onehot0", 32'($onehot0(a_oh)), 32'h1);
         chk("rnd.en_or",   32'(a_en_o), 32'(|a_oh));
         chk("rnd.err",     32'(a_err),  32'h0);
         if (a_en_o) begin
            chk("rnd.oh_at_addr", 32'(a_oh[a_addr_o]), 32'h1);
         end
      end
      a_valid = 1'b0;

      // Asynchronous reset pulse between edges
      #2; rst = 1'b1; #1;
      chk_a_reset("arst");
      rst = 1'b0;

      // Reset mid-ACTIVE clears the select before the next edge
      a_valid = 1'b1; a_en_i = 1'b1; a_addr_i = 5'd3;
      tick();
      a_valid = 1'b0;
      chk("act3.oh", 32'(a_oh), 32'h0000_0008);
      #2; rst = 1'b1; #1;
      chk("arst_act.oh", 32'(a_oh),   32'h0);
      chk("arst_act.en", 32'(a_en_o), 32'h0);
      rst = 1'b0;

      // Reset mid-GAP
      a_valid = 1'b1; a_addr_i = 5'd3;
      tick();
      a_addr_i = 5'd7;
      tick();
      a_valid = 1'b0;
      chk("pregap.busy", 32'(a_busy), 32'h1);
      #2; rst = 1'b1; #1;
      chk_a_reset("arst_gap");
      rst = 1'b0;

      // Illegal address (25 >= 20): sticky ERROR
      a_valid = 1'b1; a_en_i = 1'b1; a_addr_i = 5'd25;
      tick();
      chk("ill.err",   32'(a_err),   32'h1);
      chk("ill.oh",    32'(a_oh),    32'h0);
      chk("ill.ready", 32'(a_ready), 32'h0);
      chk("ill.busy",  32'(a_busy),  32'h0);
      a_addr_i = 5'd3;
      tick();
      tick();
      chk("ill_hold.err",   32'(a_err),   32'h1);
      chk("ill_hold.oh",    32'(a_oh),    32'h0);
      chk("ill_hold.ready", 32'(a_ready), 32'h0);
      a_valid = 1'b0;
      #2; rst = 1'b1; #1;
      chk_a_reset("ill_rst");
      rst = 1'b0;

      // Corrupt the registered one-hot while ACTIVE
      a_valid = 1'b1; a_en_i = 1'b1; a_addr_i = 5'd4;
      tick();
      a_valid = 1'b0;
      chk("act4.oh", 32'(a_oh), 32'h0000_0010);
      force u_dut.oh_q = 20'h0_0003;
      tick();
      release u_dut.oh_q;
      chk("corrupt.err", 32'(a_err), 32'h1);
      tick();
      chk("corrupt.oh",    32'(a_oh),    32'h0);
      chk("corrupt.en",    32'(a_en_o),  32'h0);
      chk("corrupt.err2",  32'(a_err),   32'h1);
      chk("corrupt.ready", 32'(a_ready), 32'h0);

      // Direct switching with no gap on the 32-line instance
      b_valid = 1'b1; b_en_i = 1'b1; b_addr_i = 5'd3;
      tick();
      chk("b_sel3.oh", b_oh, 32'h0000_0008);
      b_addr_i = 5'd31;
      tick();
      chk("b_sel31.oh",    b_oh,           32'h8000_0000);
      chk("b_sel31.addr",  32'(b_addr_o),  32'd31);
      chk("b_sel31.busy",  32'(b_busy),    32'h0);
      chk("b_sel31.ready", 32'(b_ready),   32'h1);
      b_en_i = 1'b0;
      tick();
      b_valid = 1'b0;
      chk("b_desel.oh",  b_oh,          32'h0);
      chk("b_desel.en",  32'(b_en_o),   32'h0);
      chk("b_desel.err", 32'(b_err),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
